// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host receiver: frame FSM encoding,
// default sizing and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int FIFO_BITS_DEF = 3;
  localparam int FILT_DEF      = 4;
  localparam int TIMEOUT_DEF   = 20000;

  // 8 data bits plus parity must hold an odd number of ones.
  function automatic logic parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter: a new level is
// accepted only after the synchronised line has held it for FILT cycles.
import ps2_pkg::*;

module ps2_line_filter #(
  parameter int FILT = FILT_DEF
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line_i,
  output logic line_o
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILT - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = CNT_LOAD;
    // Down-count while the line disagrees; terminal count accepts the level.
    if (sync2_q != filt_q) begin
      if (cnt_q == '0) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= CNT_LOAD;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 device-to-host receiver: filtered line sampling, frame FSM with
// parity/stop/timeout checks, and a first-word-fall-through byte FIFO.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data low on a clock fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and parity, then push or drop
import ps2_pkg::*;

module ps2_host_rx #(
  parameter int FIFO_BITS = FIFO_BITS_DEF,
  parameter int FILT      = FILT_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic clk_f, dat_f;
  logic clk_prev_q;
  logic sample;

  ps2_line_filter #(.FILT(FILT)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .line_i  (ps2_clk),
    .line_o  (clk_f)
  );

  ps2_line_filter #(.FILT(FILT)) u_dat_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .line_i  (ps2_data),
    .line_o  (dat_f)
  );

  assign sample = clk_prev_q & ~clk_f;

  ps2_state_e    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push_q, push_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    tmo_d    = '0;
    push_d   = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;

    if (state_q != ST_IDLE && !sample) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (sample && !dat_f) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d  = {dat_f, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          par_d   = dat_f;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          state_d = ST_IDLE;
          if (!dat_f) begin
            ferr_d = 1'b1;
          end else if (!parity_ok({par_q, shift_q})) begin
            perr_d = 1'b1;
          end else begin
            push_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter at TIMEOUT-1 with no edge means TIMEOUT quiet cycles elapsed.
    if (state_q != ST_IDLE && !sample && tmo_q == TMO_LAST) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      push_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_prev_q <= clk_f;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      push_q     <= push_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_BITS:0] wptr_q, wptr_d;
  logic [FIFO_BITS:0] rptr_q, rptr_d;
  logic               ovf_q, ovf_d;
  logic               empty, full, pop, push_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[FIFO_BITS] != rptr_q[FIFO_BITS]) &&
                   (wptr_q[FIFO_BITS-1:0] == rptr_q[FIFO_BITS-1:0]);
  assign pop     = ~empty & rx_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok = push_q & (~full | pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = push_q & full & ~pop;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wptr_q[FIFO_BITS-1:0]] <= shift_q;
  end

  assign rx_byte    = mem_q[rptr_q[FIFO_BITS-1:0]];
  assign rx_valid   = ~empty;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: 1 MHz clk_sys, 10 kHz PS/2 clock,
// frames driven bit by bit with hand-derived expected bytes and flags.
`timescale 1ns/1ps

module tb_ps2_host_rx;

  localparam int FIFO_BITS = 3;
  localparam int FILT      = 4;
  localparam int TIMEOUT   = 300;
  localparam int HALF      = 50;
  // Raw fall to FSM sample edge: 2 sync + FILT filter + 1 edge detect.
  localparam int SAMPLE_LAT = FILT + 3;

  logic       clk_sys  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_valid, parity_err, frame_err, overflow;

  always #500 clk_sys = ~clk_sys;

  ps2_host_rx #(.FIFO_BITS(FIFO_BITS), .FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, n_perr = 0, n_ferr = 0, n_ovf = 0, ferr_cyc = 0;
  int fall_cyc = 0, valid_lat = -1;
  logic valid_at_fall;
  logic pop_on_push = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (parity_err) n_perr <= n_perr + 1;
    if (overflow)   n_ovf  <= n_ovf + 1;
    if (frame_err) begin
      n_ferr   <= n_ferr + 1;
      ferr_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic send_bits(input logic [7:0] b, input logic par, input logic stop, input int nbits);
    logic [10:0] fr;
    int k;
    fr = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_sys);
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk       = 1'b0;
      fall_cyc      = cyc;
      valid_at_fall = rx_valid;
      valid_lat     = -1;
      for (int j = 0; j < HALF; j++) begin
        @(negedge clk_sys);
        k = cyc - fall_cyc;
        if (!valid_at_fall && rx_valid && valid_lat < 0) valid_lat = k;
        if (pop_on_push && i == nbits - 1) rx_ready = (k == SAMPLE_LAT);
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, odd_par(b), 1'b1, 11);
  endtask

  logic [7:0] tbl [9] = '{8'hA3, 8'h5C, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h36, 8'hC9, 8'h4B};
  int bp, bf, bo;

  initial begin
    repeat (5) @(negedge clk_sys);
    check("rst_valid", rx_valid, 0);
    check("rst_flags", {parity_err, frame_err, overflow}, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);

    // Single good frame and push latency
    bp = n_perr; bf = n_ferr; bo = n_ovf;
    send_byte(8'h1C);
    check("t1_par_bit", odd_par(8'h1C), 0);
    check("t1_latency", valid_lat, SAMPLE_LAT + 1);
    check("t1_valid", rx_valid, 1);
    check("t1_byte", rx_byte, 8'h1C);
    check("t1_flags", (n_perr - bp) + (n_ferr - bf) + (n_ovf - bo), 0);
    rx_ready = 1'b1;
    @(negedge clk_sys);
    rx_ready = 1'b0;
    check("t1_empty", rx_valid, 0);

    // rx_ready on an empty FIFO must not move anything
    rx_ready = 1'b1;
    repeat (3) @(negedge clk_sys);
    rx_ready = 1'b0;
    check("empty_pop", rx_valid, 0);

    // Three queued bytes, burst read
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h12);
    check("t2_head", rx_byte, 8'hE0);
    rx_ready = 1'b1;
    check("t2_rd0", rx_byte, 8'hE0);
    @(negedge clk_sys);
    check("t2_rd1", rx_byte, 8'hF0);
    @(negedge clk_sys);
    check("t2_rd2", rx_byte, 8'h12);
    check("t2_v2", rx_valid, 1);
    @(negedge clk_sys);
    rx_ready = 1'b0;
    check("t2_empty", rx_valid, 0);

    // Bad parity then bad stop
    bp = n_perr; bf = n_ferr;
    send_bits(8'h55, 1'b0, 1'b1, 11);
    repeat (20) @(negedge clk_sys);
    check("t3_perr", n_perr - bp, 1);
    check("t3_perr_ferr", n_ferr - bf, 0);
    check("t3_perr_fifo", rx_valid, 0);
    bp = n_perr; bf = n_ferr;
    send_bits(8'h55, 1'b1, 1'b0, 11);
    repeat (20) @(negedge clk_sys);
    check("t3_ferr", n_ferr - bf, 1);
    check("t3_ferr_perr", n_perr - bp, 0);
    check("t3_ferr_fifo", rx_valid, 0);

    // Overflow on the 9th byte
    bo = n_ovf;
    for (int i = 0; i < 8; i++) send_byte(tbl[i]);
    check("t4_no_ovf8", n_ovf - bo, 0);
    send_byte(tbl[8]);
    repeat (5) @(negedge clk_sys);
    check("t4_ovf9", n_ovf - bo, 1);
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_rd%0d", i), {rx_valid, rx_byte}, {1'b1, tbl[i]});
      @(negedge clk_sys);
    end
    rx_ready = 1'b0;
    check("t4_empty", rx_valid, 0);

    // Full FIFO, pop coincides with the 9th push
    bo = n_ovf;
    for (int i = 0; i < 8; i++) send_byte(tbl[i]);
    pop_on_push = 1'b1;
    send_byte(tbl[8]);
    pop_on_push = 1'b0;
    rx_ready = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("t4b_no_ovf", n_ovf - bo, 0);
    rx_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      check($sformatf("t4b_rd%0d", i), {rx_valid, rx_byte}, {1'b1, tbl[i]});
      @(negedge clk_sys);
    end
    rx_ready = 1'b0;
    check("t4b_empty", rx_valid, 0);

    // Timeout after start + 4 data bits
    bf = n_ferr;
    send_bits(8'h29, 1'b0, 1'b1, 5);
    repeat (TIMEOUT + 50) @(negedge clk_sys);
    check("t5_ferr", n_ferr - bf, 1);
    check("t5_ferr_time", ferr_cyc - fall_cyc, SAMPLE_LAT + TIMEOUT);
    check("t5_fifo", rx_valid, 0);
    bp = n_perr; bf = n_ferr;
    send_byte(8'h29);
    check("t5_byte", {rx_valid, rx_byte}, {1'b1, 8'h29});
    check("t5_flags", (n_perr - bp) + (n_ferr - bf), 0);
    rx_ready = 1'b1;
    @(negedge clk_sys);
    rx_ready = 1'b0;

    // Short glitch on ps2_clk with data low must not start a frame
    bp = n_perr; bf = n_ferr;
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (FILT - 1) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk_sys);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk_sys);
    check("t6_glitch_ferr", n_ferr - bf, 0);
    check("t6_glitch_perr", n_perr - bp, 0);
    check("t6_glitch_fifo", rx_valid, 0);

    // Reset mid-frame discards FIFO contents and the partial frame
    send_byte(8'h77);
    send_bits(8'hA5, odd_par(8'hA5), 1'b1, 5);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("t7_rst_valid", rx_valid, 0);
    check("t7_rst_flags", {parity_err, frame_err, overflow}, 0);
    bp = n_perr; bf = n_ferr; bo = n_ovf;
    reset_n = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk_sys);
    check("t7_no_flags", (n_perr - bp) + (n_ferr - bf) + (n_ovf - bo), 0);
    check("t7_fifo", rx_valid, 0);
    send_byte(8'h3C);
    check("t7_fresh", {rx_valid, rx_byte}, {1'b1, 8'h3C});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_rx.md
PS2_HOST_RX -- requirements
Module: ps2_host_rx

Interface
REQ-001 SHALL have parameter FIFO_BITS, default 3, log2 of the receive FIFO depth (8 entries).
REQ-002 SHALL have parameter FILT, default 4, the number of clk_sys cycles a synchronised line must hold a new level before that level is accepted.
REQ-003 SHALL have parameter TIMEOUT, default 20000, the number of clk_sys cycles without a PS/2 falling edge after which an open frame is aborted.
REQ-004 Port clk_sys, input, 1 bit: the single clock; all logic is rising-edge on clk_sys.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port ps2_clk, input, 1 bit: PS/2 clock line from the device, asynchronous to clk_sys.
REQ-007 Port ps2_data, input, 1 bit: PS/2 data line from the device, asynchronous to clk_sys.
REQ-008 Port rx_byte, output, 8 bits: the byte at the FIFO head.
REQ-009 Port rx_valid, output, 1 bit: the FIFO is non-empty and rx_byte is valid.
REQ-010 Port rx_ready, input, 1 bit: the consumer accepts rx_byte.
REQ-011 Port parity_err, output, 1 bit: one-cycle pulse when a frame is dropped for bad parity.
REQ-012 Port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit or a timeout.
REQ-013 Port overflow, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-014 Each of ps2_clk and ps2_data SHALL pass through a 2-flop synchroniser and then a FILT-cycle stability filter; the filtered values are the only values used downstream.
REQ-015 A falling edge of the filtered clock (1 then 0) SHALL be the only bit-sample event; the filtered data line is sampled in the same cycle the edge is detected.
REQ-016 The frame FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-017 IDLE: on a sample event with data=0 (start bit), go to DATA and clear the bit counter; with data=1, stay in IDLE with no flag.
REQ-018 DATA: shift the sampled bit in LSB-first; after the 8th bit go to PARITY.
REQ-019 PARITY: store the bit and go to STOP; parity is good when the 8 data bits plus the parity bit contain an odd number of ones.
REQ-020 STOP: on the sample, return to IDLE and take exactly one outcome, checked in this order:
- stop bit = 0: pulse frame_err and discard the frame;
- parity bad: pulse parity_err and discard the frame;
- otherwise: push the byte to the FIFO.
REQ-021 In any state other than IDLE, a cycle counter SHALL reset on every sample event; when it reaches TIMEOUT, the FSM goes to IDLE, pulses frame_err and discards the partial frame.
REQ-022 The FIFO SHALL be first-word-fall-through: rx_valid = not empty, and rx_byte = entry[rptr] combinationally.
REQ-023 A pop SHALL occur when rx_valid and rx_ready are both 1 on a clock edge; rx_ready while empty has no effect.
REQ-024 A push into a full FIFO SHALL be accepted only if a pop occurs in the same cycle; otherwise the byte is dropped and overflow pulses.
REQ-025 A simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged.
REQ-026 Pointers SHALL be FIFO_BITS+1 bits wide so full and empty are distinguished; wrap-around is natural modulo 2^(FIFO_BITS+1).
REQ-027 Latency: rx_valid SHALL rise exactly 1 cycle after the clock edge on which the STOP sample is taken, when the FIFO was empty.
REQ-028 At most one of parity_err, frame_err and overflow SHALL pulse per frame.

Reset
REQ-029 While reset_n=0, the FSM SHALL be in IDLE, the FIFO empty, and rx_valid, parity_err, frame_err and overflow all 0.
REQ-030 While reset_n=0, the synchronisers and filters SHALL hold 1 (lines idle-high) and the timeout counter SHALL be 0.
REQ-031 A reset asserted mid-frame SHALL discard the partial frame; after release, reception resumes only on a fresh start bit.

Structure
REQ-032 The FSM state encoding and the default FIFO_BITS, FILT and TIMEOUT values SHALL live in the shared package ps2_pkg.
REQ-033 The synchroniser-plus-filter SHALL be one sub-module, ps2_line_filter, instantiated once per line.
REQ-034 The FIFO SHALL be inline register-array logic, with no vendor RAM.

Verification
REQ-035 Send frame 0x1C with parity 0 and stop 1 at a 10 kHz PS/2 clock -> rx_valid=1, rx_byte=0x1C, no error pulses.
REQ-036 Send 0xE0,0xF0,0x12 with rx_ready=0 -> 3 entries held; then rx_ready=1 for 3 cycles -> outputs 0xE0,0xF0,0x12 in order, then rx_valid=0.
REQ-037 Send 0x55 with parity 0 -> one parity_err pulse, FIFO unchanged; then send 0x55 with stop bit 0 -> one frame_err pulse.
REQ-038 With rx_ready=0, send 9 good bytes -> the 9th pulses overflow and bytes 1..8 read back intact; then with a pop coinciding with the 9th push -> no overflow.
REQ-039 Stop the clock after 4 data bits -> frame_err exactly TIMEOUT cycles after the last edge; then a full frame 0x29 -> received correctly.
REQ-040 Inject a (FILT-1)-cycle glitch low on ps2_clk while idle, and assert reset_n=0 mid-frame -> no sample, byte or flag in either case.
